fetch_stall_ctrl: RTL and testbench
===================================

// Module: fetch_stall_ctrl
// PURPOSE
//  Fetch-side consumer of the decode hazard unit's stall/control signals. Owns PC write-enable,
//  next-PC select and the value loaded into the FD pipeline register. Holds fetch on RAW stalls,
//  drains the pipe behind branches/jumps until EX resolves them, and freezes fetch on HALT.
//  Sits between instruction memory/PC register and the FD latch.
// PARAMETERS
//  NOP_INSTR     16'h0800  encoding injected into FD/DX as a bubble
//  MAX_STALL     3         consecutive RAW-stall cycles allowed before err is raised
//  CTRL_TIMEOUT  4         CTRL_WAIT cycles allowed without ex_ctrl_resolved before err
// PORTS
//  clk               in   1   system clock, rising edge
//  rst_n             in   1   reset: one clock; reset is synchronous and active-low
//  if_instr          in   16  instruction fetched at current PC
//  if_pc_plus2       in   16  current PC + 2
//  hz_nop            in   1   hazard unit: RAW hazard on instruction in decode, insert bubble
//  hz_br_jmp         in   1   hazard unit: if_instr is a branch/jump (~[15] & [13])
//  ex_ctrl_resolved  in   1   EX: branch/jump in EX resolved this cycle (1-cycle pulse)
//  ex_ctrl_taken     in   1   EX: resolved control transfer is taken
//  ex_ctrl_target    in   16  EX: target PC, valid with ex_ctrl_resolved
//  pc_we             out  1   PC register write enable
//  pc_next           out  16  value written to PC when pc_we=1
//  fd_we             out  1   FD register write enable
//  fd_instr          out  16  instruction written into FD when fd_we=1
//  dx_bubble         out  1   force DX to NOP_INSTR this cycle (decode held)
//  halted            out  1   registered: HALT fetched, fetch frozen
//  err               out  1   registered, sticky: stall/ctrl timeout exceeded
// BEHAVIOUR
//  States (2-bit): RUN=0, CTRL_WAIT=1, HALTED=2. Reset (rst_n=0 at edge): state=RUN, stall_cnt=0,
//   wait_cnt=0, halted=0, err=0. While rst_n=0, comb outputs forced: pc_we=0, fd_we=1,
//   fd_instr=NOP_INSTR, dx_bubble=1.
//  Outputs pc_we/pc_next/fd_we/fd_instr/dx_bubble are combinational from state+inputs (0 latency).
//  Priority each cycle: ex_ctrl_resolved > hz_nop > HALT detect > hz_br_jmp > normal fetch.
//  RUN:
//   - hz_nop=1: pc_we=0, fd_we=0 (hold decode), dx_bubble=1; stall_cnt++ (saturating 2 bits).
//     stall_cnt reaching MAX_STALL with hz_nop still 1 -> err<=1. hz_nop=0 -> stall_cnt<=0.
//   - if_instr[15:11]==5'b00000 (HALT): fd_we=1, fd_instr=if_instr, pc_we=0, -> HALTED, halted<=1.
//   - hz_br_jmp=1: fd_we=1, fd_instr=if_instr, pc_we=1, pc_next=if_pc_plus2, -> CTRL_WAIT, wait_cnt<=0.
//   - else: fd_we=1, fd_instr=if_instr, pc_we=1, pc_next=if_pc_plus2.
//  CTRL_WAIT: fd_we=1, fd_instr=NOP_INSTR, pc_we=0; wait_cnt++ (3 bits, saturating).
//   - ex_ctrl_resolved=1: pc_we=1, pc_next = taken ? ex_ctrl_target : if_pc_plus2 - 2 ... is NOT
//     used: PC already advanced once, so pc_next = taken ? ex_ctrl_target : if_pc_plus2 - 16'd2
//     is forbidden; not-taken holds PC (pc_we=0) and fetch resumes from held PC. -> RUN.
//   - wait_cnt==CTRL_TIMEOUT without resolve -> err<=1, stay in CTRL_WAIT.
//   - hz_nop in CTRL_WAIT: dx_bubble=1, fd_we=0 (branch held in FD); resolve cannot occur then.
//  HALTED: pc_we=0, fd_we=1, fd_instr=NOP_INSTR, dx_bubble=0; exits only on reset.
//  Simultaneous resolve+hz_nop in RUN is illegal (EX holds no ctrl in RUN); resolve ignored in RUN.
//  All PC arithmetic 16-bit, wraps modulo 2^16 (0xFFFE+2 -> 0x0000); no alignment check.
//  Reset mid-CTRL_WAIT/HALTED returns to RUN next edge; pending resolve discarded.
// STRUCTURE
//  Shared package/include (cpu_defs): NOP_INSTR, HALT opcode 5'b00000, state encodings.
//  Single module; optional sub-module sat_counter (param width) for stall_cnt/wait_cnt.
// TESTING
//  1 Reset: rst_n=0 two cycles -> pc_we=0, fd_instr=16'h0800, halted=0, err=0; release -> RUN.
//  2 RAW: hz_nop=1 for 2 cycles -> pc_we=0, fd_we=0, dx_bubble=1 both; cycle 3 hz_nop=0 -> pc_we=1.
//  3 Taken branch: hz_br_jmp=1 at PC 0x0010 -> FD gets branch, PC 0x0012; 2 NOPs; resolve taken
//    target 0x0040 -> pc_next=0x0040, state RUN.
//  4 Not-taken: as 3, resolve taken=0 -> pc_we=0, next fetch from 0x0012, state RUN.
//  5 Timeouts: hz_nop held 4 cycles -> err=1 on 4th edge, stays 1; CTRL_WAIT 5 cycles no resolve -> err=1.
//  6 HALT: if_instr=16'h0000 -> halted=1 next edge, pc_we=0 forever; rst_n=0 clears halted.

Source files
------------

// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared fetch-side definitions: bubble encoding, HALT opcode, timeout limits and FSM states.
package fetch_stall_ctrl_pkg;

  localparam logic [15:0] NOP_INSTR    = 16'h0800;
  localparam logic [4:0]  HALT_OP      = 5'b00000;
  localparam int          STALL_W      = 2;
  localparam int          WAIT_W       = 3;
  localparam logic [1:0]  MAX_STALL    = 2'd3;
  localparam logic [2:0]  CTRL_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CTRL_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module fetch_stall_ctrl_sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch stall controller: drives PC/FD write enables and contents from hazard and EX resolve inputs.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_if_instr,
  input  logic [15:0] i_if_pc_plus2,
  input  logic        i_hz_nop,
  input  logic        i_hz_br_jmp,
  input  logic        i_ex_ctrl_resolved,
  input  logic        i_ex_ctrl_taken,
  input  logic [15:0] i_ex_ctrl_target,
  output logic        o_pc_we,
  output logic [15:0] o_pc_next,
  output logic        o_fd_we,
  output logic [15:0] o_fd_instr,
  output logic        o_dx_bubble,
  output logic        o_halted,
  output logic        o_err
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_halted;
  logic                r_err;
  logic                w_stall_inc;
  logic                w_stall_err;
  logic                w_wait_err;
  logic                w_wait_inc;
  logic [STALL_W-1:0]  w_stall_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt;

  assign w_wait_inc  = (r_state == ST_CTRL_WAIT);
  assign w_stall_err = w_stall_inc && (w_stall_cnt == MAX_STALL);

  fetch_stall_ctrl_sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!w_stall_inc),
    .i_inc   (w_stall_inc),
    .o_count (w_stall_cnt)
  );

  fetch_stall_ctrl_sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!w_wait_inc),
    .i_inc   (w_wait_inc),
    .o_count (w_wait_cnt)
  );

  always_comb begin
    w_state_next = r_state;
    o_pc_we      = 1'b0;
    o_pc_next    = i_if_pc_plus2;
    o_fd_we      = 1'b1;
    o_fd_instr   = i_if_instr;
    o_dx_bubble  = 1'b0;
    w_stall_inc  = 1'b0;
    w_wait_err   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (i_hz_nop) begin
          o_fd_we     = 1'b0;
          o_dx_bubble = 1'b1;
          w_stall_inc = 1'b1;
        end else if (is_halt(i_if_instr)) begin
          w_state_next = ST_HALTED;
        end else if (i_hz_br_jmp) begin
          o_pc_we      = 1'b1;
          w_state_next = ST_CTRL_WAIT;
        end else begin
          o_pc_we = 1'b1;
        end
      end
      ST_CTRL_WAIT: begin
        o_fd_instr = NOP_INSTR;
        // PC already stepped past the branch, so not-taken simply holds it.
        if (i_ex_ctrl_resolved) begin
          o_pc_we      = i_ex_ctrl_taken;
          o_pc_next    = i_ex_ctrl_target;
          w_state_next = ST_RUN;
        end else begin
          if (i_hz_nop) begin
            o_fd_we     = 1'b0;
            o_dx_bubble = 1'b1;
            w_stall_inc = 1'b1;
          end
          w_wait_err = (w_wait_cnt == CTRL_TIMEOUT);
        end
      end
      ST_HALTED: begin
        o_fd_instr = NOP_INSTR;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    if (!i_rst_n) begin
      o_pc_we     = 1'b0;
      o_fd_we     = 1'b1;
      o_fd_instr  = NOP_INSTR;
      o_dx_bubble = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == ST_HALTED) begin
        r_halted <= 1'b1;
      end
      if (w_stall_err || w_wait_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_halted = r_halted;
  assign o_err    = r_err;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed-vector bench for fetch_stall_ctrl with immediate-assertion checks.
module tb_fetch_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic        hz_nop;
  logic        hz_br_jmp;
  logic        ex_res;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic        pc_we;
  logic [15:0] pc_next;
  logic        fd_we;
  logic [15:0] fd_instr;
  logic        dx_bubble;
  logic        halted;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stall_ctrl dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_if_instr         (if_instr),
    .i_if_pc_plus2      (if_pc_plus2),
    .i_hz_nop           (hz_nop),
    .i_hz_br_jmp        (hz_br_jmp),
    .i_ex_ctrl_resolved (ex_res),
    .i_ex_ctrl_taken    (ex_taken),
    .i_ex_ctrl_target   (ex_target),
    .o_pc_we            (pc_we),
    .o_pc_next          (pc_next),
    .o_fd_we            (fd_we),
    .o_fd_instr         (fd_instr),
    .o_dx_bubble        (dx_bubble),
    .o_halted           (halted),
    .o_err              (err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic rn, input logic [15:0] ins, input logic [15:0] pc2,
                       input logic nop, input logic br, input logic res,
                       input logic tkn, input logic [15:0] tgt);
    rst_n = rn; if_instr = ins; if_pc_plus2 = pc2; hz_nop = nop; hz_br_jmp = br;
    ex_res = res; ex_taken = tkn; ex_target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held two cycles
    drive(1'b0, 16'h1234, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_pc_we", {15'd0, pc_we}, 16'd0);
    chk("rst_fd_we", {15'd0, fd_we}, 16'd1);
    chk("rst_fd_instr", fd_instr, 16'h0800);
    chk("rst_dx_bubble", {15'd0, dx_bubble}, 16'd1);
    tick(); tick();
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    drive(1'b1, 16'h1234, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("run_pc_we", {15'd0, pc_we}, 16'd1);
    chk("run_pc_next", pc_next, 16'h0004);
    chk("run_fd_instr", fd_instr, 16'h1234);
    chk("run_dx_bubble", {15'd0, dx_bubble}, 16'd0);
    tick();

    // 2: RAW stall for two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h1236, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      chk("raw_pc_we", {15'd0, pc_we}, 16'd0);
      chk("raw_fd_we", {15'd0, fd_we}, 16'd0);
      chk("raw_dx_bubble", {15'd0, dx_bubble}, 16'd1);
      tick();
    end
    drive(1'b1, 16'h1236, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("raw_release_pc_we", {15'd0, pc_we}, 16'd1);
    chk("raw_no_err", {15'd0, err}, 16'd0);
    tick();

    // 3: taken branch at PC 0x0010
    drive(1'b1, 16'h2000, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("br_fd_instr", fd_instr, 16'h2000);
    chk("br_pc_we", {15'd0, pc_we}, 16'd1);
    chk("br_pc_next", pc_next, 16'h0012);
    tick();
    drive(1'b1, 16'h1111, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("cw_fd_instr", fd_instr, 16'h0800);
    chk("cw_pc_we", {15'd0, pc_we}, 16'd0);
    chk("cw_fd_we", {15'd0, fd_we}, 16'd1);
    tick();
    drive(1'b1, 16'h1111, 16'h0014, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("cw_nop_fd_we", {15'd0, fd_we}, 16'd0);
    chk("cw_nop_dx_bubble", {15'd0, dx_bubble}, 16'd1);
    chk("cw_nop_pc_we", {15'd0, pc_we}, 16'd0);
    tick();
    drive(1'b1, 16'h1111, 16'h0014, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040);
    chk("tkn_pc_we", {15'd0, pc_we}, 16'd1);
    chk("tkn_pc_next", pc_next, 16'h0040);
    chk("tkn_fd_instr", fd_instr, 16'h0800);
    tick();
    drive(1'b1, 16'h1234, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("tkn_run_pc_next", pc_next, 16'h0042);
    chk("tkn_run_fd_instr", fd_instr, 16'h1234);
    tick();

    // 4: not-taken branch holds PC
    drive(1'b1, 16'h2000, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b1, 16'h1111, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b1, 16'h1111, 16'h0014, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
    chk("ntkn_pc_we", {15'd0, pc_we}, 16'd0);
    tick();
    drive(1'b1, 16'h1456, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ntkn_run_pc_we", {15'd0, pc_we}, 16'd1);
    chk("ntkn_run_pc_next", pc_next, 16'h0014);
    chk("ntkn_run_fd_instr", fd_instr, 16'h1456);
    tick();

    // 5a: stall timeout, err on 4th edge and sticky
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'h1456, 16'h0016, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      chk($sformatf("stall_err_edge%0d", i), {15'd0, err}, (i == 4) ? 16'd1 : 16'd0);
    end
    drive(1'b1, 16'h1456, 16'h0016, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("stall_err_sticky", {15'd0, err}, 16'd1);
    drive(1'b0, 16'h1456, 16'h0016, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("err_cleared", {15'd0, err}, 16'd0);

    // 5b: CTRL_WAIT timeout, err on 5th edge without resolve
    drive(1'b1, 16'h2000, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      chk($sformatf("wait_err_edge%0d", i), {15'd0, err}, (i == 5) ? 16'd1 : 16'd0);
    end
    drive(1'b1, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("wait_still_cw", fd_instr, 16'h0800);
    drive(1'b1, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE);
    chk("wait_late_resolve", pc_next, 16'hFFFE);
    tick();
    chk("wait_err_sticky", {15'd0, err}, 16'd1);
    drive(1'b0, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();

    // 6: HALT freezes fetch until reset
    drive(1'b1, 16'h0000, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("halt_pc_we", {15'd0, pc_we}, 16'd0);
    chk("halt_fd_instr", fd_instr, 16'h0000);
    chk("halt_pre_halted", {15'd0, halted}, 16'd0);
    tick();
    chk("halt_halted", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234, 16'h0022, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0050);
      chk("halted_pc_we", {15'd0, pc_we}, 16'd0);
      chk("halted_fd_instr", fd_instr, 16'h0800);
      chk("halted_dx_bubble", {15'd0, dx_bubble}, 16'd0);
      tick();
    end
    chk("halted_stays", {15'd0, halted}, 16'd1);
    drive(1'b0, 16'h1234, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("halt_reset_clears", {15'd0, halted}, 16'd0);
    drive(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("post_halt_run", {15'd0, pc_we}, 16'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
